// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
//   Bundles the core-side memory signals served by mem_responder.
//   master : the core side. It drives the fetch/data addresses, the store
//            data and the byte enables, and receives the read data and ready.
//   slave  : the responder. It receives the requests and drives the read
//            data and ready.
//   Signals:
//     pc_to_mem        [ACTUAL_ADDR_W] instruction fetch byte address
//     mem_addr         [ACTUAL_ADDR_W] data byte address
//     st_data          [DATA_W]        store data
//     we               [WE_W]          byte write enables
//     ld_data_for_inst [DATA_W]        fetched instruction word
//     ld_data          [DATA_W]        loaded data word
//     ready            1               array cleared, accesses honoured
// ---------------------------------------------------------------------------
interface mem_responder_if #(
    parameter int ACTUAL_ADDR_W = 13,
    parameter int DATA_W        = 64,
    parameter int WE_W          = 8
);
    logic [ACTUAL_ADDR_W-1:0] pc_to_mem;
    logic [ACTUAL_ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]        st_data;
    logic [WE_W-1:0]          we;
    logic [DATA_W-1:0]        ld_data_for_inst;
    logic [DATA_W-1:0]        ld_data;
    logic                     ready;

    modport master (
        output pc_to_mem, mem_addr, st_data, we,
        input  ld_data_for_inst, ld_data, ready
    );

    modport slave (
        input  pc_to_mem, mem_addr, st_data, we,
        output ld_data_for_inst, ld_data, ready
    );
endinterface

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the core. It keeps a 2^(ACTUAL_ADDR_W-3) x 64-bit
//   word store with byte write enables. It serves an instruction fetch port
//   (pc_to_mem -> ld_data_for_inst) and a data load/store port
//   (mem_addr/st_data/we -> ld_data). The read data goes through a registered
//   pipeline LOAD_LATENCY stages deep. After reset, a clear FSM writes zero to
//   every word and only then raises ready.
//
//   Ports:
//     clk   clock, rising edge
//     rstn  asynchronous active-low reset
//     bus   mem_responder_if.slave (addresses, store data, byte enables in;
//           read data and ready out)
//
//   Optional feature, selected by the macro MEM_WRITE_FWD_EN:
//     When the macro is defined, a read of the word being written in the same
//     cycle returns the merged value: enabled bytes come from st_data and the
//     other bytes come from the old contents. This applies to both ports.
//     When the macro is undefined, such a read returns the old contents.
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int LOAD_LATENCY  = 1,
    parameter int ACTUAL_ADDR_W = 13,
    parameter int DATA_W        = 64,
    parameter int WE_W          = 8
) (
    input  logic             clk,
    input  logic             rstn,
    mem_responder_if.slave   bus
);
    localparam int IDX_W = ACTUAL_ADDR_W - 3;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state_reg;
    logic [IDX_W-1:0]  clr_cnt_reg;
    logic              ready_reg;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  inst_idx;
    logic [IDX_W-1:0]  data_idx;
    logic              clr_en;
    logic              wr_en;
    logic              sample_en;
    logic [DATA_W-1:0] inst_rd;
    logic [DATA_W-1:0] data_rd;

    // Accesses are word aligned, so the low three address bits are dropped.
    logic              unused_addr_lsbs;
    assign unused_addr_lsbs = ^{bus.pc_to_mem[2:0], bus.mem_addr[2:0]};

    assign inst_idx  = bus.pc_to_mem[ACTUAL_ADDR_W-1:3];
    assign data_idx  = bus.mem_addr[ACTUAL_ADDR_W-1:3];

    // Including rstn here means that a write on an edge where reset is held
    // cannot reach the array.
    assign clr_en    = rstn && (state_reg == ST_CLEAR);
    assign wr_en     = rstn && (state_reg == ST_READY) && (|bus.we);
    assign sample_en = (state_reg == ST_READY);

    // Clear FSM: one word is zeroed per cycle. The last word is written on the
    // same edge that moves the FSM to READY, so CLEAR lasts exactly DEPTH cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= ST_CLEAR;
            clr_cnt_reg <= '0;
            ready_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    if (clr_cnt_reg == '1) begin
                        state_reg <= ST_READY;
                        ready_reg <= 1'b1;
                    end
                end
                ST_READY: begin
                    ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= ST_CLEAR;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    // Array write port. The array has no reset, so it can map onto block RAM;
    // the clear FSM is what zeroes it.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_cnt_reg] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < WE_W; b++) begin
                if (bus.we[b]) begin
                    mem[data_idx][8*b +: 8] <= bus.st_data[8*b +: 8];
                end
            end
        end
    end

`ifdef MEM_WRITE_FWD_EN
    // Merge the bytes being written into any same-cycle read of that word.
    always_comb begin
        inst_rd = mem[inst_idx];
        data_rd = mem[data_idx];
        if (wr_en) begin
            for (int b = 0; b < WE_W; b++) begin
                if (bus.we[b]) begin
                    data_rd[8*b +: 8] = bus.st_data[8*b +: 8];
                    if (inst_idx == data_idx) begin
                        inst_rd[8*b +: 8] = bus.st_data[8*b +: 8];
                    end
                end
            end
        end
    end
`else
    // Read-first: the nonblocking array update is not yet visible here.
    assign inst_rd = mem[inst_idx];
    assign data_rd = mem[data_idx];
`endif

    // Load-latency pipeline. Stage 0 samples the array. Later stages carry
    // data only. While not READY, zeros are shifted in.
    for (genvar gi = 0; gi < LOAD_LATENCY; gi++) begin : g_pipe
        logic [DATA_W-1:0] inst_stage_reg;
        logic [DATA_W-1:0] data_stage_reg;

        if (gi == 0) begin : g_first
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    inst_stage_reg <= '0;
                    data_stage_reg <= '0;
                end else begin
                    inst_stage_reg <= sample_en ? inst_rd : '0;
                    data_stage_reg <= sample_en ? data_rd : '0;
                end
            end
        end else begin : g_next
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    inst_stage_reg <= '0;
                    data_stage_reg <= '0;
                end else begin
                    inst_stage_reg <= g_pipe[gi-1].inst_stage_reg;
                    data_stage_reg <= g_pipe[gi-1].data_stage_reg;
                end
            end
        end
    end

    assign bus.ld_data_for_inst = g_pipe[LOAD_LATENCY-1].inst_stage_reg;
    assign bus.ld_data          = g_pipe[LOAD_LATENCY-1].data_stage_reg;
    assign bus.ready            = ready_reg;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//   Drives identical stimulus into two mem_responder instances, one with
//   LOAD_LATENCY=1 and one with LOAD_LATENCY=3. A word-array model checks both
//   of them every cycle. Directed checks with hand-computed literals cover the
//   main scenarios.
// ---------------------------------------------------------------------------
module tb_mem_responder;
    localparam int AW    = 13;
    localparam int DW    = 64;
    localparam int WEW   = 8;
    localparam int DEPTH = 1 << (AW - 3);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rstn;
    logic [AW-1:0]  pc;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  sd;
    logic [WEW-1:0] we;

    mem_responder_if #(.ACTUAL_ADDR_W(AW), .DATA_W(DW), .WE_W(WEW)) bus1 ();
    mem_responder_if #(.ACTUAL_ADDR_W(AW), .DATA_W(DW), .WE_W(WEW)) bus3 ();

    assign bus1.pc_to_mem = pc;
    assign bus1.mem_addr  = addr;
    assign bus1.st_data   = sd;
    assign bus1.we        = we;
    assign bus3.pc_to_mem = pc;
    assign bus3.mem_addr  = addr;
    assign bus3.st_data   = sd;
    assign bus3.we        = we;

    mem_responder #(.LOAD_LATENCY(1), .ACTUAL_ADDR_W(AW), .DATA_W(DW), .WE_W(WEW)) dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1)
    );

    mem_responder #(.LOAD_LATENCY(3), .ACTUAL_ADDR_W(AW), .DATA_W(DW), .WE_W(WEW)) dut3 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus3)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Word array plus a record of the values sampled on recent edges.
    // Index 0 holds the most recent edge. An L-cycle port shows index L-1.
    logic [DW-1:0] mm [DEPTH];
    int            m_edges;
    bit            m_ready;
    logic [DW-1:0] h_inst [3];
    logic [DW-1:0] h_data [3];

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        int ri;
        ri = int'(a >> 3);
        v  = mm[ri];
`ifdef MEM_WRITE_FWD_EN
        if (we != 0 && ri == int'(addr >> 3)) begin
            for (int b = 0; b < WEW; b++)
                if (we[b]) v[8*b +: 8] = sd[8*b +: 8];
        end
`endif
        return v;
    endfunction

    always @(posedge clk or negedge rstn) begin
        logic [DW-1:0] ni, nd;
        if (!rstn) begin
            foreach (mm[i]) mm[i] = '0;
            m_edges = 0;
            m_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                h_inst[i] = '0;
                h_data[i] = '0;
            end
        end else begin
            ni = m_ready ? model_read(pc)   : '0;
            nd = m_ready ? model_read(addr) : '0;
            h_inst[2] = h_inst[1]; h_inst[1] = h_inst[0]; h_inst[0] = ni;
            h_data[2] = h_data[1]; h_data[1] = h_data[0]; h_data[0] = nd;
            if (m_ready && we != 0) begin
                for (int b = 0; b < WEW; b++)
                    if (we[b]) mm[int'(addr >> 3)][8*b +: 8] = sd[8*b +: 8];
            end
            if (!m_ready) begin
                m_edges++;
                if (m_edges == DEPTH) m_ready = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready_l1",  {63'b0, bus1.ready},   {63'b0, m_ready});
            chk("ready_l3",  {63'b0, bus3.ready},   {63'b0, m_ready});
            chk("inst_l1",   bus1.ld_data_for_inst, h_inst[0]);
            chk("data_l1",   bus1.ld_data,          h_data[0]);
            chk("inst_l3",   bus3.ld_data_for_inst, h_inst[2]);
            chk("data_l3",   bus3.ld_data,          h_data[2]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic [AW-1:0] p, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [WEW-1:0] w);
        @(negedge clk);
        pc   = p;
        addr = a;
        sd   = d;
        we   = w;
    endtask

    task automatic count_clear(input string name, input bit kill_we);
        int cnt;
        cnt = 0;
        while (cnt < 2000) begin
            @(posedge clk);
            #1;
            cnt++;
            if (kill_we && cnt == 10) we = '0;
            if (bus1.ready) break;
        end
        chk(name, 64'(cnt), 64'd1024);
    endtask

    localparam logic [63:0] W_MERGED = 64'h11223344AAAAAAAA;
    localparam logic [63:0] W_BEEF   = 64'h00000000DEADBEEF;
    localparam logic [63:0] W_ONES   = 64'hFFFFFFFFFFFFFFFF;

    initial begin
        rstn = 1'b1;
        pc = '0; addr = '0; sd = '0; we = '0;
        #2 rstn = 1'b0;
        #1 cmp_en = 1'b1;
        chk("rst_ready_l1", {63'b0, bus1.ready}, 64'd0);
        chk("rst_ready_l3", {63'b0, bus3.ready}, 64'd0);
        chk("rst_data_l1",  bus1.ld_data, 64'd0);
        chk("rst_inst_l3",  bus3.ld_data_for_inst, 64'd0);
        repeat (3) @(negedge clk);

        // Write attempt to word 5 while the clear runs; it must not stick.
        pc = 13'h28; addr = 13'h28; sd = W_ONES; we = 8'hFF;
        #2 rstn = 1'b1;
        count_clear("clear_cycles", 1'b1);
        repeat (3) @(negedge clk);
        chk("word5_after_clear_l1", bus1.ld_data, 64'd0);
        chk("word5_after_clear_l3", bus3.ld_data, 64'd0);

        // Byte-enable write, then a read of the merged word.
        step(13'h0, 13'h40, 64'h1122334455667788, 8'hFF);
        step(13'h0, 13'h40, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        step(13'h0, 13'h80, W_BEEF, 8'hFF);
        step(13'h40, 13'h40, 64'h0, 8'h00);
        @(negedge clk);
        chk("byte_we_data_l1", bus1.ld_data, W_MERGED);
        chk("model_pin_merged", h_data[0], W_MERGED);

        // Dual port: fetch 0x40 while loading 0x80.
        step(13'h40, 13'h80, 64'h0, 8'h00);
        @(negedge clk);
        chk("dual_inst_l1", bus1.ld_data_for_inst, W_MERGED);
        chk("dual_data_l1", bus1.ld_data, W_BEEF);
        repeat (2) @(negedge clk);
        chk("dual_inst_l3", bus3.ld_data_for_inst, W_MERGED);
        chk("dual_data_l3", bus3.ld_data, W_BEEF);

        // Back-to-back stream: fill words 0..7, then read a new address every cycle.
        for (int i = 0; i < 8; i++)
            step(13'h0, 13'(i * 8), 64'h0101010101010101 * 64'(i + 1), 8'hFF);
        for (int i = 0; i < 8; i++)
            step(13'(i * 8), 13'(56 - i * 8), 64'h0, 8'h00);
        step(13'h47, 13'h47, 64'h0, 8'h00);
        @(negedge clk);
        chk("alias_47_l1", bus1.ld_data, W_MERGED);
        chk("model_pin_word7", mm[7], 64'h0808080808080808);

        // Same-cycle write and fetch of the same word.
        step(13'h40, 13'h40, W_ONES, 8'hFF);
        @(negedge clk);
`ifdef MEM_WRITE_FWD_EN
        chk("hazard_inst_l1", bus1.ld_data_for_inst, W_ONES);
`else
        chk("hazard_inst_l1", bus1.ld_data_for_inst, W_MERGED);
`endif
        step(13'h40, 13'h40, 64'h0, 8'h00);
        @(negedge clk);
        chk("after_hazard_l1", bus1.ld_data_for_inst, W_ONES);

        // Reset while a read is in flight.
        step(13'h80, 13'h80, 64'h0, 8'h00);
        repeat (3) @(negedge clk);
        chk("pre_reset_data_l3", bus3.ld_data, W_BEEF);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_data_l3",  bus3.ld_data, 64'd0);
        chk("midrst_inst_l3",  bus3.ld_data_for_inst, 64'd0);
        chk("midrst_ready_l1", {63'b0, bus1.ready}, 64'd0);
        pc = 13'h40; addr = 13'h40;
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        count_clear("reclear_cycles", 1'b0);
        repeat (4) @(negedge clk);
        chk("reclear_40_l1", bus1.ld_data, 64'd0);
        chk("reclear_40_l3", bus3.ld_data, 64'd0);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's memory interface: serves instruction fetches (pc_to_mem -> ld_data_for_inst) and data load/store (mem_addr, st_data, we -> ld_data).
- Dual-port 64-bit word store with byte write enables and a configurable load-latency pipeline.
- Sits beside core_periphs at the top level, driven directly by its truncated address outputs.
- After reset, a clear FSM zeroes the whole array before asserting ready.

Parameters:
- LOAD_LATENCY, 1: cycles from address presented to read data valid on both ports; legal values >= 1.
- ACTUAL_ADDR_W, 13: byte-address width; depth = 2^(ACTUAL_ADDR_W-3) 64-bit words.
- DATA_W, 64: word width; fixed at 64.
- WE_W, 8: byte write-enable width; DATA_W/8.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- pc_to_mem  input  ACTUAL_ADDR_W  instruction fetch byte address.
- mem_addr  input  ACTUAL_ADDR_W  data byte address.
- st_data  input  DATA_W  store data.
- we  input  WE_W  byte write enables; bit i writes st_data[8i+7:8i].
- ld_data_for_inst  output  DATA_W  fetched instruction word.
- ld_data  output  DATA_W  loaded data word.
- ready  output  1  high once clearing is done and accesses are honoured.

Behaviour:
- Word index = addr[ACTUAL_ADDR_W-1:3]. addr[2:0] is ignored, so all accesses are word-aligned.
- Reset (rstn=0, async):
  - ready=0, ld_data=0, ld_data_for_inst=0.
  - All latency-pipeline stages cleared; FSM enters CLEAR with clear counter = 0.
  - Array contents are not reset directly.
- FSM:
  - CLEAR: each cycle writes 0 to word[counter], then counter+1. At counter = depth-1, go to READY on the next edge. CLEAR lasts exactly depth cycles after rstn deasserts.
  - READY: ready=1; stays in READY until reset.
- During CLEAR:
  - we is ignored (no user writes).
  - Reads are not sampled; the pipelines shift in 0, so both outputs read 0.
- Write (READY): on the rising edge where we != 0, each enabled byte of word[mem_addr index] is updated. Other bytes are unchanged.
- Read (READY):
  - Both ports sample their address on every edge.
  - Data for the address sampled at edge N appears on the output after edge N+LOAD_LATENCY-1. Outputs are registered, so LOAD_LATENCY=1 means data is valid in the cycle after the address is presented.
  - Pipeline stages between sample and output hold data only, not addresses.
- Same-cycle write and read (either port) to the same word:
  - Default is read-first: the read returns the pre-write contents.
  - See the optional feature for forwarding.
- Fetch and data port addressing the same word: independent reads; the data-port write hazard is as above.
- Reset asserted mid-operation (including mid-CLEAR): FSM restarts CLEAR from counter 0 and the pipelines flush to 0. A write on the reset edge is discarded.
- Addresses wrap naturally; there is no out-of-range condition.

Optional Feature:
- Macro: MEM_WRITE_FWD_EN.
- Defined: a same-cycle read of the word being written returns the merged value. Enabled bytes come from st_data; the rest come from old contents. This applies to both ports, with latency unchanged.
- Undefined: read-first behaviour as above, and the merge logic is absent.

Test Plan:
- Clear after reset: release rstn with depth=1024 -> ready=0 for exactly 1024 cycles, then 1; reading word 5 afterwards gives ld_data=0. A we=0xFF write during CLEAR is not retained.
- Byte-enable write:
  - Write 0x1122334455667788 to addr 0x40 with we=0xFF.
  - Then write 0xAAAAAAAAAAAAAAAA with we=0x0F.
  - Read addr 0x40 -> 0x11223344AAAAAAAA.
- Latency, with LOAD_LATENCY=1 and LOAD_LATENCY=3: present a new address every cycle -> the data stream appears 1 or 3 cycles after each address respectively, back-to-back with no bubbles. Addr 0x47 reads the same word as 0x40.
- Dual port: fetch addr 0x40 while loading addr 0x80 (holding 0xDEADBEEF) -> ld_data_for_inst=0x11223344AAAAAAAA and ld_data=0xDEADBEEF in the same cycle.
- Read/write hazard:
  - Write 0xFFFFFFFFFFFFFFFF (we=0xFF) to 0x40 while pc_to_mem=0x40.
  - Without MEM_WRITE_FWD_EN: fetch returns 0x11223344AAAAAAAA.
  - With MEM_WRITE_FWD_EN: fetch returns 0xFFFFFFFFFFFFFFFF.
  - A subsequent read returns 0xFFFFFFFFFFFFFFFF in both builds.
- Reset mid-operation: assert rstn=0 while in READY with a read in flight -> outputs go to 0 immediately and ready=0. After release, CLEAR runs for the full 1024 cycles and addr 0x40 reads 0.
